// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline front end.
//   addr_t        : 32-bit byte address
//   instr_t       : 32-bit instruction word
//   fetch_entry_t : fetched instruction paired with its address
//   PC_STEP       : sequential PC increment
package mips_pipe_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] instr_t;

   typedef struct packed {
      addr_t  pc;
      instr_t instr;
   } fetch_entry_t;

   localparam addr_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used by the fetch unit (address queue and
// instruction buffer).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push_i, data_i  : write an entry (caller guarantees not full unless popping)
//   pop_i           : drop the head entry (caller guarantees not empty)
//   flush_i         : empty the FIFO; wins over push/pop
//   count_o         : number of valid entries (0..DEPTH)
//   head_o          : oldest entry, read straight from storage
module fetch_fifo #(
   parameter int  DEPTH = 2,
   parameter type T     = logic [31:0]
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  T                       data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic [$clog2(DEPTH):0] count_o,
   output T                       head_o
);

   localparam int PW = $clog2(DEPTH);

   T              mem_q [DEPTH];
   logic [PW-1:0] rd_q;
   logic [PW-1:0] wr_q;
   logic [PW:0]   count_q;

   // Pointer, occupancy and storage update; pointers wrap since DEPTH is a power of 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + PW'(1'b1);
         end
         if (pop_i) begin
            rd_q <= rd_q + PW'(1'b1);
         end
         count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit_chk.sv
// Protocol checker for the fetch unit.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (checks disabled in reset)
//   rsp_valid_i  : imem response valid
//   out_i        : outstanding request counter
//   aq_count_i   : address queue occupancy
//   keep_i       : response is being written into the instruction buffer
//   buf_full_i   : instruction buffer is full
module fetch_unit_chk #(
   parameter int CW = 2
) (
   input logic          clk,
   input logic          rst,
   input logic          rsp_valid_i,
   input logic [CW-1:0] out_i,
   input logic [CW-1:0] aq_count_i,
   input logic          keep_i,
   input logic          buf_full_i
);

   a_rsp_without_req : assert property (@(posedge clk) disable iff (rst)
      rsp_valid_i |-> (out_i != '0));

   a_buf_overflow : assert property (@(posedge clk) disable iff (rst)
      keep_i |-> !buf_full_i);

   a_aq_tracks_out : assert property (@(posedge clk) disable iff (rst)
      out_i == aq_count_i);

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the fetch PC, issues word fetches under a credit limit,
// buffers responses and presents one instruction per cycle downstream.
// A redirect flushes the buffer and drops every response still in flight.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr        : fetch request channel
//   imem_rsp_valid/data              : in-order response channel (no back-pressure)
//   stall_IF                         : hold current IF output
//   redirect_valid/redirect_pc       : taken branch/jump target
//   valid_IF/instr_IF/pc_IF/pc_plus4_IF : head of the instruction buffer
module fetch_unit
   import mips_pipe_pkg::*;
#(
   parameter addr_t RESET_PC = 32'h0000_0000,
   parameter int    DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        stall_IF,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        valid_IF,
   output logic [31:0] instr_IF,
   output logic [31:0] pc_IF,
   output logic [31:0] pc_plus4_IF
);

   localparam int CW = $clog2(DEPTH) + 1;

   addr_t         fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] count_s;
   logic [CW-1:0] aq_count_s;
   logic [CW:0]   inflight_s;
   addr_t         aq_head_s;
   fetch_entry_t  head_s;
   fetch_entry_t  buf_wdata_s;
   logic          req_fire_s;
   logic          rsp_keep_s;
   logic          pop_s;

   // Credit counts buffered entries plus requests in flight, so a response
   // always finds room in the buffer.
   assign inflight_s     = {1'b0, count_s} + {1'b0, out_q};
   assign imem_req_valid = (inflight_s < (CW+1)'(DEPTH)) & ~rst;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire_s     = imem_req_valid & imem_req_ready;

   // A response landing in a redirect cycle is wrong-path as well.
   assign rsp_keep_s  = imem_rsp_valid & (drop_q == '0) & ~redirect_valid;
   assign buf_wdata_s = '{pc: aq_head_s, instr: imem_rsp_data};

   assign valid_IF    = (count_s != '0);
   assign pop_s       = valid_IF & ~stall_IF & ~redirect_valid;
   assign instr_IF    = valid_IF ? head_s.instr : 32'h0000_0000;
   assign pc_IF       = valid_IF ? head_s.pc : 32'h0000_0000;
   assign pc_plus4_IF = valid_IF ? (head_s.pc + PC_STEP) : 32'h0000_0000;

   // Next-state for PC, outstanding and drop counters.
   always_comb begin
      out_d = out_q + CW'(req_fire_s) - CW'(imem_rsp_valid);

      if (redirect_valid) begin
         // Everything accepted and not yet answered is wrong-path.
         drop_d = out_d;
      end else if (imem_rsp_valid && (drop_q != '0)) begin
         drop_d = drop_q - CW'(1'b1);
      end else begin
         drop_d = drop_q;
      end

      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      end else if (req_fire_s) begin
         fetch_pc_d = fetch_pc_q + PC_STEP;
      end else begin
         fetch_pc_d = fetch_pc_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         out_q      <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
      end
   end

   // Addresses of accepted requests, consumed in order by responses (kept or dropped).
   fetch_fifo #(.DEPTH(DEPTH), .T(addr_t)) u_addr_q (
      .clk     (clk),
      .rst     (rst),
      .push_i  (req_fire_s),
      .data_i  (fetch_pc_q),
      .pop_i   (imem_rsp_valid),
      .flush_i (1'b0),
      .count_o (aq_count_s),
      .head_o  (aq_head_s)
   );

   fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_instr_buf (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rsp_keep_s),
      .data_i  (buf_wdata_s),
      .pop_i   (pop_s),
      .flush_i (redirect_valid),
      .count_o (count_s),
      .head_o  (head_s)
   );

   fetch_unit_chk #(.CW(CW)) u_chk (
      .clk         (clk),
      .rst         (rst),
      .rsp_valid_i (imem_rsp_valid),
      .out_i       (out_q),
      .aq_count_i  (aq_count_s),
      .keep_i      (rsp_keep_s),
      .buf_full_i  (count_s == CW'(DEPTH))
   );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import mips_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        stall_IF = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        valid_IF;
   logic [31:0] instr_IF;
   logic [31:0] pc_IF;
   logic [31:0] pc_plus4_IF;

   int          n_checks = 0;
   int          n_err    = 0;
   int          cyc      = 0;
   int          lat      = 1;
   logic [31:0] q_addr[$];
   int          q_due[$];

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .stall_IF       (stall_IF),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .valid_IF       (valid_IF),
      .instr_IF       (instr_IF),
      .pc_IF          (pc_IF),
      .pc_plus4_IF    (pc_plus4_IF)
   );

   function automatic logic [31:0] idata(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: record an accepted request, advance, then present the due response.
   task automatic tick();
      if (!rst && imem_req_valid && imem_req_ready) begin
         q_addr.push_back(imem_req_addr);
         q_due.push_back(cyc + lat);
      end
      @(posedge clk);
      #1;
      cyc++;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = idata(q_addr[0]);
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end
   endtask

   task automatic wait_valid(input int bound, input string tag);
      int n = 0;
      while (valid_IF !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      check(tag, {31'd0, valid_IF}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: reset state and first fetches with latency 1
      tick();
      tick();
      check("rst_valid", {31'd0, valid_IF}, 32'd0);
      check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("rst_pc", pc_IF, 32'h0);
      check("rst_instr", instr_IF, 32'h0);
      check("rst_pc4", pc_plus4_IF, 32'h0);
      rst = 1'b0;
      #1;
      check("c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("c1_addr", imem_req_addr, 32'h0);
      tick();
      check("c2_valid", {31'd0, valid_IF}, 32'd0);
      check("c2_addr", imem_req_addr, 32'h4);
      tick();
      check("c3_valid", {31'd0, valid_IF}, 32'd1);
      check("c3_pc", pc_IF, 32'h0);
      check("c3_instr", instr_IF, idata(32'h0));
      check("c3_pc4", pc_plus4_IF, 32'h4);
      check("c3_no_credit", {31'd0, imem_req_valid}, 32'd0);
      tick();
      check("c4_pc", pc_IF, 32'h4);
      check("c4_addr", imem_req_addr, 32'h8);
      tick();
      check("c5_valid", {31'd0, valid_IF}, 32'd0);
      tick();
      check("c6_pc", pc_IF, 32'h8);

      // 2: stall three cycles
      stall_IF = 1'b1;
      tick();
      check("st1_pc", pc_IF, 32'h8);
      check("st1_credit", {31'd0, imem_req_valid}, 32'd0);
      tick();
      check("st2_pc", pc_IF, 32'h8);
      check("st2_instr", instr_IF, idata(32'h8));
      tick();
      check("st3_pc", pc_IF, 32'h8);
      stall_IF = 1'b0;
      tick();
      check("st_rel_pc", pc_IF, 32'hC);
      check("st_rel_addr", imem_req_addr, 32'h10);

      // 3: redirect with two fetches in flight (latency 3)
      lat = 3;
      tick();
      tick();
      check("r3_inflight_credit", {31'd0, imem_req_valid}, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      tick();
      redirect_valid = 1'b0;
      check("r3_valid", {31'd0, valid_IF}, 32'd0);
      tick();
      check("r3_addr", imem_req_addr, 32'h100);
      wait_valid(8, "r3_wait");
      check("r3_pc", pc_IF, 32'h100);
      check("r3_instr", instr_IF, idata(32'h100));
      lat = 1;
      tick();
      check("r3_pc_next", pc_IF, 32'h104);
      tick();
      tick();
      check("r4_pre_pc", pc_IF, 32'h108);

      // 4: redirect during stall with a response arriving the same cycle
      stall_IF       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      tick();
      stall_IF       = 1'b0;
      redirect_valid = 1'b0;
      check("r4_valid", {31'd0, valid_IF}, 32'd0);
      check("r4_addr", imem_req_addr, 32'h200);
      wait_valid(6, "r4_wait");
      check("r4_pc", pc_IF, 32'h200);

      // 5: memory not ready for 5 cycles, then redirect to an unaligned target near wrap
      imem_req_ready = 1'b0;
      repeat (5) tick();
      check("nr_valid", {31'd0, valid_IF}, 32'd0);
      check("nr_addr", imem_req_addr, 32'h208);
      imem_req_ready = 1'b1;
      wait_valid(6, "nr_wait");
      check("nr_pc", pc_IF, 32'h208);
      tick();
      check("nr_pc_next", pc_IF, 32'h20C);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFD;
      tick();
      redirect_valid = 1'b0;
      check("wr_valid", {31'd0, valid_IF}, 32'd0);
      wait_valid(6, "wr_wait");
      check("wr_pc", pc_IF, 32'hFFFF_FFFC);
      check("wr_pc4", pc_plus4_IF, 32'h0);
      check("wr_instr", instr_IF, idata(32'hFFFF_FFFC));
      tick();
      check("wr_pc_next", pc_IF, 32'h0);
      check("wr_pc4_next", pc_plus4_IF, 32'h4);

      // 6: reset mid-stream with two buffered entries
      stall_IF = 1'b1;
      tick();
      tick();
      check("mr_full_valid", {31'd0, valid_IF}, 32'd1);
      check("mr_full_credit", {31'd0, imem_req_valid}, 32'd0);
      rst            = 1'b1;
      imem_rsp_valid = 1'b0;
      q_addr.delete();
      q_due.delete();
      #1;
      check("mr_valid", {31'd0, valid_IF}, 32'd0);
      check("mr_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("mr_pc", pc_IF, 32'h0);
      tick();
      rst      = 1'b0;
      stall_IF = 1'b0;
      #1;
      check("mr_restart_valid", {31'd0, imem_req_valid}, 32'd1);
      check("mr_restart_addr", imem_req_addr, 32'h0);
      wait_valid(6, "mr_wait");
      check("mr_first_pc", pc_IF, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
